// File: rtl/pipe_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder: operation
// encodings, legal parameter ranges and the parameter legality check.
package pipe_cla_adder_pkg;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ADC = 2'b10;

  localparam int unsigned WIDTH_MIN  = 8;
  localparam int unsigned WIDTH_MAX  = 64;
  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 8;
  localparam int unsigned GROUP_MIN  = 1;
  localparam int unsigned GROUP_MAX  = 64;

  function automatic bit params_legal(int unsigned width, int unsigned stages,
                                      int unsigned group);
    if (width < WIDTH_MIN || width > WIDTH_MAX) return 1'b0;
    if (stages < STAGES_MIN || stages > STAGES_MAX) return 1'b0;
    if (group < GROUP_MIN || group > GROUP_MAX) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    if (((width / stages) % group) != 0) return 1'b0;
    return 1'b1;
  endfunction

endpackage

// File: rtl/pipe_cla_adder_if.sv
// Operand/result handshake bundle of the pipelined adder. The slave modport is
// the adder's view, the master modport is the producer/consumer side.
interface pipe_cla_adder_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cIn;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             cOut;
  logic             ovf;
  logic             zero;

  modport slave (
    input  in_valid, x, y, cIn, mode, out_ready,
    output in_ready, out_valid, s, cOut, ovf, zero
  );

  modport master (
    output in_valid, x, y, cIn, mode, out_ready,
    input  in_ready, out_valid, s, cOut, ovf, zero
  );
endinterface

// File: rtl/pipe_cla_adder_cla_slice.sv
// Combinational W-bit carry-lookahead adder: GROUP-bit lookahead groups plus a
// flat group-level lookahead across the slice.
module cla_slice #(
  parameter int unsigned W     = 16,
  parameter int unsigned GROUP = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         c_i,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  localparam int Ng = int'(W / GROUP);
  localparam int Gw = int'(GROUP);

  logic [W-1:0]  g, p, c;
  logic [Ng-1:0] gg, gp;
  logic [Ng:0]   gc;
  logic          term;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    term = 1'b0;
    for (int j = 0; j < Ng; j++) begin
      gg[j] = 1'b0;
      gp[j] = 1'b1;
      for (int i = 0; i < Gw; i++) begin
        gg[j] = g[j*Gw+i] | (p[j*Gw+i] & gg[j]);
        gp[j] = gp[j] & p[j*Gw+i];
      end
    end
    // Each group carry is a flat sum of products, not a ripple through groups.
    for (int j = 0; j <= Ng; j++) begin
      gc[j] = c_i;
      for (int i = 0; i < j; i++) gc[j] = gc[j] & gp[i];
      for (int k = 0; k < j; k++) begin
        term = gg[k];
        for (int i = k + 1; i < j; i++) term = term & gp[i];
        gc[j] = gc[j] | term;
      end
    end
    for (int j = 0; j < Ng; j++) begin
      for (int i = 0; i < Gw; i++) begin
        c[j*Gw+i] = gc[j];
        for (int m = 0; m < i; m++) c[j*Gw+i] = c[j*Gw+i] & p[j*Gw+m];
        for (int k = 0; k < i; k++) begin
          term = g[j*Gw+k];
          for (int m = k + 1; m < i; m++) term = term & p[j*Gw+m];
          c[j*Gw+i] = c[j*Gw+i] | term;
        end
      end
    end
    s_o = p ^ c;
    c_o = gc[Ng];
  end

endmodule

// File: rtl/pipe_cla_adder.sv
// Pipelined adder: stage k adds slice k of the operands with the carry from
// stage k-1; skew registers carry the full operands and partial sum along.
module pipe_cla_adder
  import pipe_cla_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned GROUP  = 4
) (
  input logic             clk,
  input logic             rst_n,
  pipe_cla_adder_if.slave bus
);
  localparam int unsigned W    = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  if (!params_legal(WIDTH, STAGES, GROUP)) begin : g_param_check
    $error("pipe_cla_adder: illegal WIDTH/STAGES/GROUP combination");
  end

  logic                         adv;
  logic [WIDTH-1:0]             b_eff;
  logic                         c0;
  logic [STAGES-1:0][WIDTH-1:0] a_d, a_q, b_d, b_q, s_in, sum_d, sum_q;
  logic [STAGES-1:0]            c_in, carry_d, carry_q, valid_d, valid_q;
  logic [STAGES-1:0][W-1:0]     slice_s;
  logic                         ovf_d, ovf_q, zero_d, zero_q;
  logic                         unused_ab;

  assign adv = bus.out_ready | ~valid_q[Last];

  always_comb begin
    b_eff = bus.y;
    c0    = 1'b0;
    case (bus.mode)
      MODE_ADD: ;
      MODE_SUB: begin
        b_eff = ~bus.y;
        c0    = 1'b1;
      end
      MODE_ADC: c0 = bus.cIn;
      default: ;
    endcase
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] sum_k;

    if (k == 0) begin : g_head
      assign a_d[k]     = bus.x;
      assign b_d[k]     = b_eff;
      assign s_in[k]    = '0;
      assign c_in[k]    = c0;
      assign valid_d[k] = bus.in_valid;
    end else begin : g_body
      assign a_d[k]     = a_q[k-1];
      assign b_d[k]     = b_q[k-1];
      assign s_in[k]    = sum_q[k-1];
      assign c_in[k]    = carry_q[k-1];
      assign valid_d[k] = valid_q[k-1];
    end

    cla_slice #(
      .W     (W),
      .GROUP (GROUP)
    ) u_slice (
      .a_i (a_d[k][k*W +: W]),
      .b_i (b_d[k][k*W +: W]),
      .c_i (c_in[k]),
      .s_o (slice_s[k]),
      .c_o (carry_d[k])
    );

    always_comb begin
      sum_k            = s_in[k];
      sum_k[k*W +: W]  = slice_s[k];
    end
    assign sum_d[k] = sum_k;
  end

  // Flags come from the completed sum in the final stage, before registering.
  assign ovf_d  = (a_d[Last][WIDTH-1] == b_d[Last][WIDTH-1]) &
                  (sum_d[Last][WIDTH-1] != a_d[Last][WIDTH-1]);
  assign zero_d = (sum_d[Last] == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else if (adv) begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  // Operands leaving the last stage have no consumer.
  assign unused_ab = ^{a_q[Last], b_q[Last]};

  assign bus.in_ready  = adv;
  assign bus.out_valid = valid_q[Last];
  assign bus.s         = sum_q[Last];
  assign bus.cOut      = carry_q[Last];
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: directed corner cases on a 32-bit/2-stage build
// plus randomized traffic on several geometries against an arithmetic model.
module tb_pipe_cla_adder;
  import pipe_cla_adder_pkg::*;

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        v;
    logic        z;
  } exp_t;

  localparam int NBeats = 400;
  localparam int CW [4] = '{8, 32, 32, 64};
  localparam int CS [4] = '{1, 2, 4, 8};
  localparam int CG [4] = '{4, 4, 4, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_rn;
  bit   dir_done = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain unsigned and signed arithmetic at width w.
  function automatic exp_t model(int w, logic [1:0] m, logic ci, logic [63:0] a,
                                 logic [63:0] b);
    exp_t r;
    logic [65:0] modv, ua, ub, ur;
    logic signed [65:0] sa, sb, sr, lim;
    modv = 66'd1 << w;
    ua   = {2'b00, a};
    ub   = {2'b00, b};
    sa   = a[w-1] ? $signed(ua - modv) : $signed(ua);
    sb   = b[w-1] ? $signed(ub - modv) : $signed(ub);
    lim  = $signed(modv >> 1);
    case (m)
      MODE_SUB: begin
        ur  = ua - ub;
        r.c = (ua >= ub);
        sr  = sa - sb;
      end
      MODE_ADC: begin
        ur  = ua + ub + {65'd0, ci};
        r.c = (ur >= modv);
        sr  = sa + sb + $signed({65'd0, ci});
      end
      default: begin
        ur  = ua + ub;
        r.c = (ur >= modv);
        sr  = sa + sb;
      end
    endcase
    ur  = ur & (modv - 66'd1);
    r.s = ur[63:0];
    r.z = (ur == 66'd0);
    r.v = (sr >= lim) || (sr < -lim);
    return r;
  endfunction

  // ---------------- directed: WIDTH=32, STAGES=2 ----------------
  pipe_cla_adder_if #(.WIDTH(32)) dif ();

  pipe_cla_adder #(
    .WIDTH  (32),
    .STAGES (2),
    .GROUP  (4)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] m,
                       input logic ci);
    dif.in_valid = 1'b1;
    dif.x        = a;
    dif.y        = b;
    dif.mode     = m;
    dif.cIn      = ci;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] es, input logic ec,
                            input logic ev, input logic ez);
    check_eq({tag, "_valid"}, dif.out_valid, 1);
    check_eq({tag, "_s"}, dif.s, es);
    check_eq({tag, "_cout"}, dif.cOut, ec);
    check_eq({tag, "_ovf"}, dif.ovf, ev);
    check_eq({tag, "_zero"}, dif.zero, ez);
  endtask

  // Called at a negedge; returns at the negedge where the result is visible.
  task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] m, input logic ci, input logic [31:0] es,
                        input logic ec, input logic ev, input logic ez);
    drive(a, b, m, ci);
    #1 check_eq({tag, "_rdy"}, dif.in_ready, 1);
    @(negedge clk);
    dif.in_valid = 1'b0;
    dif.mode     = ~m;
    dif.cIn      = ~ci;
    dif.x        = $urandom;
    dif.y        = $urandom;
    check_eq({tag, "_early"}, dif.out_valid, 0);
    @(negedge clk);
    expect_out(tag, es, ec, ev, ez);
  endtask

  initial begin : directed
    rst_n         = 1'b0;
    dif.in_valid  = 1'b0;
    dif.x         = '0;
    dif.y         = '0;
    dif.mode      = MODE_ADD;
    dif.cIn       = 1'b0;
    dif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", dif.out_valid, 0);
    check_eq("rst_ready", dif.in_ready, 1);
    check_eq("rst_s", dif.s, 0);
    check_eq("rst_cout", dif.cOut, 0);
    check_eq("rst_ovf", dif.ovf, 0);
    check_eq("rst_zero", dif.zero, 0);
    dif.out_ready = 1'b1;
    rst_n         = 1'b1;

    single("add_ovf", 32'h7FFF_FFFF, 32'h1, MODE_ADD, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    single("sub_neg", 32'd5, 32'd7, MODE_SUB, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    single("sub_eq", 32'd7, 32'd7, MODE_SUB, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    single("adc_wrap", 32'hFFFF_FFFF, 32'h0, MODE_ADC, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
    single("add_nocin", 32'hFFFF_FFFF, 32'h0, MODE_ADD, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    single("add_wrap", 32'hFFFF_FFFF, 32'h1, MODE_ADD, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    single("rsv_add", 32'd3, 32'd4, 2'b11, 1'b1, 32'd7, 1'b0, 1'b0, 1'b0);
    single("sub_ovf", 32'h8000_0000, 32'h1, MODE_SUB, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // Back-to-back beats with a three-cycle output stall.
    drive(32'd1, 32'd1, MODE_ADD, 1'b0);
    @(negedge clk);
    drive(32'd2, 32'd2, MODE_ADD, 1'b0);
    @(negedge clk);
    drive(32'd3, 32'd3, MODE_ADD, 1'b0);
    expect_out("b2b_first", 32'd2, 1'b0, 1'b0, 1'b0);
    dif.out_ready = 1'b0;
    #1 check_eq("stall_rdy0", dif.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_valid", dif.out_valid, 1);
      check_eq("stall_s", dif.s, 2);
      check_eq("stall_rdy", dif.in_ready, 0);
    end
    dif.out_ready = 1'b1;
    @(negedge clk);
    dif.in_valid = 1'b0;
    expect_out("b2b_second", 32'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    expect_out("b2b_third", 32'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("b2b_drain", dif.out_valid, 0);

    // Reset with two beats in flight.
    drive(32'd100, 32'd1, MODE_ADD, 1'b0);
    @(negedge clk);
    drive(32'd200, 32'd2, MODE_ADD, 1'b0);
    @(negedge clk);
    dif.in_valid = 1'b0;
    rst_n        = 1'b0;
    #1;
    check_eq("arst_valid", dif.out_valid, 0);
    check_eq("arst_ready", dif.in_ready, 1);
    check_eq("arst_s", dif.s, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("arst_stale", dif.out_valid, 0);
    end
    single("post_rst", 32'd10, 32'd20, MODE_ADD, 1'b0, 32'd30, 1'b0, 1'b0, 1'b0);
    dir_done = 1'b1;
  end

  // ---------------- randomized regression on several geometries ----------------
  initial begin
    rst_rn = 1'b0;
    repeat (3) @(negedge clk);
    rst_rn = 1'b1;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_rnd
    localparam int W = CW[gi];
    bit done = 1'b0;

    pipe_cla_adder_if #(.WIDTH(W)) rif ();

    pipe_cla_adder #(
      .WIDTH  (W),
      .STAGES (CS[gi]),
      .GROUP  (CG[gi])
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_rn),
      .bus   (rif.slave)
    );

    initial begin : stim
      exp_t        q[$];
      exp_t        e;
      int          sent;
      int          got;
      logic [63:0] rx, ry;
      sent          = 0;
      got           = 0;
      rif.in_valid  = 1'b0;
      rif.x         = '0;
      rif.y         = '0;
      rif.mode      = MODE_ADD;
      rif.cIn       = 1'b0;
      rif.out_ready = 1'b0;
      @(posedge rst_rn);
      for (int cyc = 0; cyc < 4000 && got < NBeats; cyc++) begin
        @(negedge clk);
        rx = {$urandom, $urandom};
        ry = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) rx = '1;
        if ($urandom_range(0, 7) == 0) ry = rx;
        rif.in_valid  = (sent < NBeats) && ($urandom_range(0, 3) != 0);
        rif.x         = rx[W-1:0];
        rif.y         = ry[W-1:0];
        rif.mode      = 2'($urandom_range(0, 3));
        rif.cIn       = 1'($urandom_range(0, 1));
        rif.out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (rif.in_valid && rif.in_ready) begin
          q.push_back(model(W, rif.mode, rif.cIn, 64'(rif.x), 64'(rif.y)));
          sent++;
        end
        if (rif.out_valid && rif.out_ready) begin
          if (q.size() == 0) begin
            check_eq($sformatf("rnd%0d_spurious", gi), rif.out_valid, 0);
          end else begin
            e = q.pop_front();
            check_eq($sformatf("rnd%0d_s", gi), 64'(rif.s), e.s);
            check_eq($sformatf("rnd%0d_cout", gi), rif.cOut, e.c);
            check_eq($sformatf("rnd%0d_ovf", gi), rif.ovf, e.v);
            check_eq($sformatf("rnd%0d_zero", gi), rif.zero, e.z);
          end
          got++;
        end
      end
      check_eq($sformatf("rnd%0d_count", gi), got, NBeats);
      rif.in_valid = 1'b0;
      done         = 1'b1;
    end
  end

  initial begin : summary
    wait (dir_done && g_rnd[0].done && g_rnd[1].done && g_rnd[2].done && g_rnd[3].done);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
